// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: widths, instruction field positions, opcodes and
// the per-opcode control lookup used by the decode stage.
package decode_stage_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 7;
  localparam int INSTR_WIDTH = 27;
  localparam int NUM_REGS    = 32;
  localparam int REG_W       = 5;
  localparam int OPC_W       = 5;

  localparam int OPC_HI = 26;
  localparam int OPC_LO = 22;
  localparam int RD_HI  = 21;
  localparam int RD_LO  = 17;
  localparam int RS1_HI = 16;
  localparam int RS1_LO = 12;
  localparam int RS2_HI = 11;
  localparam int RS2_LO = 7;
  localparam int IMM_HI = 11;

  localparam logic [OPC_W-1:0] OP_NOP   = 5'h00;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'h01;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'h02;
  localparam logic [OPC_W-1:0] OP_AND   = 5'h03;
  localparam logic [OPC_W-1:0] OP_OR    = 5'h04;
  localparam logic [OPC_W-1:0] OP_ADDI  = 5'h08;
  localparam logic [OPC_W-1:0] OP_LOAD  = 5'h10;
  localparam logic [OPC_W-1:0] OP_STORE = 5'h11;
  localparam logic [OPC_W-1:0] OP_BEQ   = 5'h18;
  localparam logic [OPC_W-1:0] OP_BNE   = 5'h19;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'h1A;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  typedef struct packed {
    logic  legal;
    logic  use_rs1;
    logic  use_rs2;
    ctrl_t ctrl;
  } dec_t;

  function automatic dec_t decode_opcode(input logic [OPC_W-1:0] op);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.ctrl.reg_write = 1'b1;
      end
      OP_ADDI: begin
        d.use_rs1 = 1'b1;
        d.ctrl.reg_write = 1'b1;
      end
      OP_LOAD: begin
        d.use_rs1 = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read = 1'b1;
      end
      OP_STORE: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.ctrl.branch = 1'b1;
      end
      OP_JMP: d.ctrl.branch = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch inputs, write-back port and ID/EX outputs of the decode stage.
// master drives the stage inputs (fetch/execute side), slave is the decode stage.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [ADDR_WIDTH-1:0]  i_Pc;
  logic [INSTR_WIDTH-1:0] i_Instruction;
  logic                   i_Prediction;
  logic                   i_Flush;
  logic                   i_Wb_En;
  logic [REG_W-1:0]       i_Wb_Reg;
  logic [DATA_WIDTH-1:0]  i_Wb_Data;

  logic                   o_Freeze;
  logic                   o_Valid;
  logic [ADDR_WIDTH-1:0]  o_Pc;
  logic [OPC_W-1:0]       o_Opcode;
  logic [REG_W-1:0]       o_Rd;
  logic [REG_W-1:0]       o_Rs1;
  logic [REG_W-1:0]       o_Rs2;
  logic [DATA_WIDTH-1:0]  o_Rs1_Data;
  logic [DATA_WIDTH-1:0]  o_Rs2_Data;
  logic [DATA_WIDTH-1:0]  o_Imm;
  logic                   o_Reg_Write;
  logic                   o_Mem_Read;
  logic                   o_Mem_Write;
  logic                   o_Branch;
  logic                   o_Prediction;
  logic                   o_Illegal;

  modport master (
    output i_Pc, i_Instruction, i_Prediction, i_Flush, i_Wb_En, i_Wb_Reg, i_Wb_Data,
    input  o_Freeze, o_Valid, o_Pc, o_Opcode, o_Rd, o_Rs1, o_Rs2, o_Rs1_Data,
           o_Rs2_Data, o_Imm, o_Reg_Write, o_Mem_Read, o_Mem_Write, o_Branch,
           o_Prediction, o_Illegal
  );

  modport slave (
    input  i_Pc, i_Instruction, i_Prediction, i_Flush, i_Wb_En, i_Wb_Reg, i_Wb_Data,
    output o_Freeze, o_Valid, o_Pc, o_Opcode, o_Rd, o_Rs1, o_Rs2, o_Rs1_Data,
           o_Rs2_Data, o_Imm, o_Reg_Write, o_Mem_Read, o_Mem_Write, o_Branch,
           o_Prediction, o_Illegal
  );

endinterface

// File: rtl/decode_stage_register_file.sv
// Register file: two combinational read ports with write-through bypass, one
// clocked write port; r0 is hard zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_W-1:0]     rd_addr1,
  input  logic [ADDR_W-1:0]     rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_reg != '0) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Bypass lets an instruction see a value written back in the same cycle.
  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 != '0) rd_data1 = (wb_en && wb_reg == rd_addr1) ? wb_data : regs[rd_addr1];
  end

  always_comb begin
    rd_data2 = '0;
    if (rd_addr2 != '0) rd_data2 = (wb_en && wb_reg == rd_addr2) ? wb_data : regs[rd_addr2];
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: cracks the fetched instruction, reads operands,
// detects load-use hazards and registers the result into ID/EX.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  decode_stage_if.slave bus
);

  function automatic logic signed [DATA_WIDTH-1:0] sign_extend(input logic [IMM_HI:0] v);
    return DATA_WIDTH'(signed'(v));
  endfunction

  logic [OPC_W-1:0]             opcode;
  logic [REG_W-1:0]             rd, rs1, rs2;
  logic signed [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0]        rs1_data, rs2_data;
  dec_t                         dec;
  ctrl_t                        ctrl;
  logic                         hazard, kill;

  logic                         vld_p1;
  logic [ADDR_WIDTH-1:0]        pc_p1;
  logic [OPC_W-1:0]             opc_p1;
  logic [REG_W-1:0]             rd_p1, rs1_p1, rs2_p1;
  logic [DATA_WIDTH-1:0]        rs1_data_p1, rs2_data_p1;
  logic signed [DATA_WIDTH-1:0] imm_p1;
  ctrl_t                        ctrl_p1;
  logic                         pred_p1, ill_p1;

  assign opcode = bus.i_Instruction[OPC_HI:OPC_LO];
  assign rd     = bus.i_Instruction[RD_HI:RD_LO];
  assign rs1    = bus.i_Instruction[RS1_HI:RS1_LO];
  assign rs2    = bus.i_Instruction[RS2_HI:RS2_LO];
  assign imm    = sign_extend(bus.i_Instruction[IMM_HI:0]);
  assign dec    = decode_opcode(opcode);

  always_comb begin
    ctrl = dec.ctrl;
    if (rd == '0) ctrl.reg_write = 1'b0;
  end

  register_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (REG_W)
  ) u_register_file (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (bus.i_Wb_En),
    .wb_reg  (bus.i_Wb_Reg),
    .wb_data (bus.i_Wb_Data),
    .rd_addr1(rs1),
    .rd_addr2(rs2),
    .rd_data1(rs1_data),
    .rd_data2(rs2_data)
  );

  // A load sitting in ID/EX cannot forward to its immediate consumer.
  always_comb begin
    hazard = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) &&
             ((dec.use_rs1 && rd_p1 == rs1) || (dec.use_rs2 && rd_p1 == rs2));
  end

  assign bus.o_Freeze = hazard && !bus.i_Flush && !reset;
  assign kill         = bus.i_Flush || hazard || !dec.legal;

  // ---- ID/EX boundary (p1) ----
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      opc_p1      <= '0;
      rd_p1       <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      ctrl_p1     <= '0;
      pred_p1     <= 1'b0;
      ill_p1      <= !reset && !bus.i_Flush && !dec.legal;
    end else begin
      vld_p1      <= 1'b1;
      pc_p1       <= bus.i_Pc;
      opc_p1      <= opcode;
      rd_p1       <= rd;
      rs1_p1      <= rs1;
      rs2_p1      <= rs2;
      rs1_data_p1 <= rs1_data;
      rs2_data_p1 <= rs2_data;
      imm_p1      <= imm;
      ctrl_p1     <= ctrl;
      pred_p1     <= bus.i_Prediction;
      ill_p1      <= 1'b0;
    end
  end

  assign bus.o_Valid      = vld_p1;
  assign bus.o_Pc         = pc_p1;
  assign bus.o_Opcode     = opc_p1;
  assign bus.o_Rd         = rd_p1;
  assign bus.o_Rs1        = rs1_p1;
  assign bus.o_Rs2        = rs2_p1;
  assign bus.o_Rs1_Data   = rs1_data_p1;
  assign bus.o_Rs2_Data   = rs2_data_p1;
  assign bus.o_Imm        = imm_p1;
  assign bus.o_Reg_Write  = ctrl_p1.reg_write;
  assign bus.o_Mem_Read   = ctrl_p1.mem_read;
  assign bus.o_Mem_Write  = ctrl_p1.mem_write;
  assign bus.o_Branch     = ctrl_p1.branch;
  assign bus.o_Prediction = pred_p1;
  assign bus.o_Illegal    = ill_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus random traffic
// checked against an instruction-level reference model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  decode_stage_if bus ();

  decode_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [6:0]  pc;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        pred;
    logic        ill;
  } out_t;

  out_t        exp_q[$];
  out_t        last_exp = '0;
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;
  bit          model_freeze = 0;
  logic [6:0]  pc_ctr = 7'd0;

  function automatic out_t sample_dut();
    out_t a;
    a.valid = bus.o_Valid;      a.pc   = bus.o_Pc;        a.opcode = bus.o_Opcode;
    a.rd    = bus.o_Rd;         a.rs1  = bus.o_Rs1;       a.rs2    = bus.o_Rs2;
    a.d1    = bus.o_Rs1_Data;   a.d2   = bus.o_Rs2_Data;  a.imm    = bus.o_Imm;
    a.rw    = bus.o_Reg_Write;  a.mr   = bus.o_Mem_Read;  a.mw     = bus.o_Mem_Write;
    a.br    = bus.o_Branch;     a.pred = bus.o_Prediction; a.ill   = bus.o_Illegal;
    return a;
  endfunction

  // Monitor: every ID/EX update is compared against the oldest prediction.
  always begin
    out_t e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample_dut();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL idex t=%0t got=%h required=%h", $time, a, e);
      end
    end
  end

  // Instruction classes: 0 illegal, 1 nop, 2 alu reg, 3 addi, 4 load, 5 store, 6 cond branch, 7 jmp
  function automatic int op_class(input logic [4:0] op);
    case (op)
      5'h00: return 1;
      5'h01, 5'h02, 5'h03, 5'h04: return 2;
      5'h08: return 3;
      5'h10: return 4;
      5'h11: return 5;
      5'h18, 5'h19: return 6;
      5'h1A: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic logic [26:0] mk_r(input logic [4:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
    return {op, d, s1, s2, 7'h00};
  endfunction

  function automatic logic [26:0] mk_i(input logic [4:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [11:0] im);
    return {op, d, s1, im};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic wen,
                                          input logic [4:0] wreg, input logic [31:0] wdata);
    if (r == 5'd0) return 32'd0;
    if (wen && wreg == r) return wdata;
    return rf[r];
  endfunction

  task automatic step(input logic rst, input logic [26:0] ins, input logic [6:0] pc,
                      input logic pred, input logic flush, input logic wen,
                      input logic [4:0] wreg, input logic [31:0] wdata);
    int   cls;
    logic u1, u2, hz, efrz;
    logic [4:0] op, d, s1, s2;
    out_t n;
    @(negedge clk);
    reset = rst;
    bus.i_Instruction = ins; bus.i_Pc = pc; bus.i_Prediction = pred;
    bus.i_Flush = flush; bus.i_Wb_En = wen; bus.i_Wb_Reg = wreg; bus.i_Wb_Data = wdata;
    #1;
    op = ins[26:22]; d = ins[21:17]; s1 = ins[16:12]; s2 = ins[11:7];
    cls = op_class(op);
    u1 = (cls == 2 || cls == 3 || cls == 4 || cls == 5 || cls == 6);
    u2 = (cls == 2 || cls == 5 || cls == 6);
    hz = last_exp.valid && last_exp.mr && last_exp.rd != 0 &&
         ((u1 && last_exp.rd == s1) || (u2 && last_exp.rd == s2));
    efrz = !rst && !flush && hz;
    checks++;
    if (bus.o_Freeze !== efrz) begin
      errors++;
      $display("FAIL freeze t=%0t got=%b required=%b", $time, bus.o_Freeze, efrz);
    end
    n = '0;
    if (!rst) begin
      if (flush || hz || cls == 0) begin
        n.ill = !flush && cls == 0;
      end else begin
        n.valid = 1'b1; n.pc = pc; n.opcode = op; n.rd = d; n.rs1 = s1; n.rs2 = s2;
        n.d1 = operand(s1, wen, wreg, wdata);
        n.d2 = operand(s2, wen, wreg, wdata);
        n.imm = {{20{ins[11]}}, ins[11:0]};
        n.rw = (cls == 2 || cls == 3 || cls == 4) && d != 0;
        n.mr = (cls == 4);
        n.mw = (cls == 5);
        n.br = (cls == 6 || cls == 7);
        n.pred = pred;
      end
    end
    exp_q.push_back(n);
    last_exp = n;
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end else if (wen && wreg != 0) begin
      rf[wreg] = wdata;
    end
    model_freeze = efrz;
  endtask

  // Acts as fetch: re-presents the same instruction while decode is frozen.
  task automatic issue(input logic [26:0] ins, input logic wen = 1'b0,
                       input logic [4:0] wreg = 5'd0, input logic [31:0] wdata = 32'd0);
    int guard;
    logic pred;
    pred = 1'($urandom_range(0, 1));
    pc_ctr++;
    step(1'b0, ins, pc_ctr, pred, 1'b0, wen, wreg, wdata);
    guard = 0;
    while (model_freeze && guard < 4) begin
      step(1'b0, ins, pc_ctr, pred, 1'b0, 1'b0, 5'd0, 32'd0);
      guard++;
    end
  endtask

  initial begin
    logic [26:0] ins;
    logic [6:0]  rpc;
    logic        rpred;
    logic [4:0]  op;
    logic [4:0]  legal_ops [11];
    legal_ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h10, 5'h11, 5'h18, 5'h19, 5'h1A};
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    bus.i_Instruction = '0; bus.i_Pc = '0; bus.i_Prediction = 1'b0; bus.i_Flush = 1'b0;
    bus.i_Wb_En = 1'b0; bus.i_Wb_Reg = '0; bus.i_Wb_Data = '0;

    repeat (2) step(1'b1, 27'd0, 7'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (3) issue(27'd0);
    for (int r = 1; r < 32; r++) issue(mk_r(OP_ADD, 5'd0, 5'(r), 5'(r)));

    issue(27'd0, 1'b1, 5'd5, 32'h1234);
    issue(mk_r(OP_ADD, 5'd3, 5'd5, 5'd5));
    issue(mk_r(OP_ADD, 5'd0, 5'd5, 5'd5));

    issue(mk_i(OP_LOAD, 5'd7, 5'd1, 12'h004));
    issue(mk_r(OP_ADD, 5'd8, 5'd7, 5'd1));

    issue(mk_i(OP_LOAD, 5'd7, 5'd1, 12'h008));
    step(1'b0, mk_r(OP_ADD, 5'd8, 5'd7, 5'd1), 7'd90, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    issue(27'd0);

    issue(mk_i(OP_ADDI, 5'd2, 5'd9, 12'hFFF), 1'b1, 5'd9, 32'h000000AA);
    issue(mk_r(5'h1F, 5'd1, 5'd2, 5'd3));
    issue(mk_i(OP_STORE, 5'd0, 5'd9, 12'h800));

    issue(mk_i(OP_LOAD, 5'd6, 5'd0, 12'h010));
    step(1'b0, mk_r(OP_BEQ, 5'd0, 5'd1, 5'd6), 7'd91, 1'b0, 1'b0, 1'b1, 5'd1, 32'h55);
    step(1'b0, mk_r(OP_BEQ, 5'd0, 5'd1, 5'd6), 7'd91, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    issue(mk_i(OP_LOAD, 5'd7, 5'd1, 12'h00C));
    step(1'b0, mk_r(OP_ADD, 5'd8, 5'd7, 5'd1), 7'd92, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, mk_r(OP_ADD, 5'd8, 5'd7, 5'd1), 7'd92, 1'b1, 1'b0, 1'b1, 5'd3, 32'h77);
    issue(mk_r(OP_ADD, 5'd8, 5'd7, 5'd1));

    for (int k = 0; k < 31; k++) issue(27'd0, 1'b1, 5'(k + 1), $urandom);

    ins = '0; rpc = '0; rpred = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (!model_freeze) begin
        op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 10)];
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 7'($urandom)};
        rpc = 7'($urandom);
        rpred = 1'($urandom_range(0, 1));
      end
      step($urandom_range(0, 99) == 0, ins, rpc, rpred, $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
